// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer behind the FF46 register: start delay, then a byte-by-byte copy of one page into OAM.
// Build option OAM_DMA_ECHO_MAP_EN folds source pages E0-FF onto C0-DF for the DMA address only.
module oam_dma_ctrl #(
  parameter int          CYCLES_PER_BYTE = 4,
  parameter int          DMA_LEN         = 160,
  parameter logic [15:0] REG_ADDR        = 16'hFF46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  output logic [7:0]  reg_dout,
  output logic        reg_oe,
  output logic [15:0] dma_a,
  output logic        dma_run,
  output logic        vram_to_oam,
  output logic        oam_addr_ndma,
  output logic        oam_wr,
  output logic        dma_done
);

  localparam int PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam logic [PW-1:0] LAST_PH  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    LAST_IDX = 8'(DMA_LEN - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [7:0]    r_src_reg;
  logic [7:0]    r_src_act;
  logic [7:0]    r_idx;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] r_start_cnt;
  logic          r_start_pend;
  logic          r_done;

  logic          w_reg_hit;
  logic          w_wr_hit;
  logic          w_expire;
  logic          w_byte_end;
  logic [7:0]    w_page;

  assign w_reg_hit  = (a == REG_ADDR);
  assign w_wr_hit   = cpu_wr && w_reg_hit;
  // A fresh register write on the expiry edge re-arms the delay instead of starting.
  assign w_expire   = r_start_pend && !w_wr_hit && (r_start_cnt == LAST_PH);
  assign w_byte_end = (r_state == S_RUN) && (r_phase == LAST_PH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_reg    <= 8'h00;
      r_start_pend <= 1'b0;
      r_start_cnt  <= '0;
    end else if (w_wr_hit) begin
      r_src_reg    <= d;
      r_start_pend <= 1'b1;
      r_start_cnt  <= '0;
    end else if (r_start_pend) begin
      if (r_start_cnt == LAST_PH)
        r_start_pend <= 1'b0;
      else
        r_start_cnt <= r_start_cnt + 1'b1;
    end
  end

  // Expiry outranks the final byte, so a restart on the last beat keeps RUN with no done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_src_act <= 8'h00;
      r_idx     <= 8'h00;
      r_phase   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_expire) begin
        r_src_act <= r_src_reg;
        r_idx     <= 8'h00;
        r_phase   <= '0;
        r_state   <= S_RUN;
      end else if (r_state == S_RUN) begin
        r_phase <= (r_phase == LAST_PH) ? '0 : r_phase + 1'b1;
        if (w_byte_end) begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 8'h01;
          end
        end
      end
    end
  end

`ifdef OAM_DMA_ECHO_MAP_EN
  assign w_page = (r_src_act >= 8'hE0) ? (r_src_act - 8'h20) : r_src_act;
`else
  assign w_page = r_src_act;
`endif

  assign reg_dout      = r_src_reg;
  assign reg_oe        = cpu_rd && w_reg_hit;
  assign dma_a         = {w_page, r_idx};
  assign dma_run       = (r_state == S_RUN);
  assign oam_addr_ndma = (r_state != S_RUN);
  // VRAM detection looks at the raw page; folding only ever targets WRAM.
  assign vram_to_oam   = (r_state == S_RUN) && (r_src_act[7:5] == 3'b100);
  assign oam_wr        = w_byte_end;
  assign dma_done      = r_done;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: directed scenarios plus random writes, compared every cycle against a
// timeline model (transfer start edge + elapsed cycles) kept here.
module tb_oam_dma_ctrl;
  localparam int CPB = 4;
  localparam int LEN = 160;
  localparam logic [15:0] RA = 16'hFF46;

  logic        clk, reset, cpu_wr, cpu_rd;
  logic [15:0] a;
  logic [7:0]  d;
  logic [7:0]  reg_dout;
  logic        reg_oe, dma_run, vram_to_oam, oam_addr_ndma, oam_wr, dma_done;
  logic [15:0] dma_a;

  oam_dma_ctrl #(.CYCLES_PER_BYTE(CPB), .DMA_LEN(LEN), .REG_ADDR(RA)) dut (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .a(a), .d(d),
    .reg_dout(reg_dout), .reg_oe(reg_oe), .dma_a(dma_a), .dma_run(dma_run),
    .vram_to_oam(vram_to_oam), .oam_addr_ndma(oam_addr_ndma), .oam_wr(oam_wr),
    .dma_done(dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0, total = 0;
  // model: edge count, pending start edge, active transfer start edge and page
  int n = 0, m_exp = 0, m_S = 0;
  logic [7:0] m_src_reg = 8'h00, m_page = 8'h00;
  logic m_pend = 1'b0, m_active = 1'b0, m_done = 1'b0;
  int strobes = 0, dones = 0, vram_cnt = 0, ndma_lo = 0, first_wr = -1;

  function automatic logic [7:0] fold(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_MAP_EN
    return (p >= 8'hE0) ? p - 8'h20 : p;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_src_reg = 8'h00; m_pend = 1'b0; m_active = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    logic started;
    n++;
    started = 1'b0;
    m_done = 1'b0;
    if (cpu_wr && a == RA) begin
      m_src_reg = d; m_pend = 1'b1; m_exp = n + CPB;
    end else if (m_pend && m_exp == n) begin
      m_pend = 1'b0; m_active = 1'b1; m_S = n; m_page = m_src_reg; started = 1'b1;
    end
    if (!started && m_active && n == m_S + LEN * CPB) begin
      m_active = 1'b0; m_done = 1'b1;
    end
  endtask

  task automatic check_all();
    int e;
    e = n - m_S;
    chk("dma_run", dma_run, m_active);
    chk("oam_addr_ndma", oam_addr_ndma, !m_active);
    chk("oam_wr", oam_wr, m_active && (e % CPB == CPB - 1));
    chk("dma_done", dma_done, m_done);
    chk("vram_to_oam", vram_to_oam, m_active && m_page[7:5] == 3'b100);
    chk("reg_dout", reg_dout, m_src_reg);
    chk("reg_oe", reg_oe, cpu_rd && a == RA);
    if (m_active) chk("dma_a", dma_a, {fold(m_page), 8'(e / CPB)});
    strobes += oam_wr;
    dones += dma_done;
    vram_cnt += vram_to_oam;
    ndma_lo += !oam_addr_ndma;
    if (oam_wr && first_wr < 0) first_wr = n;
  endtask

  task automatic cyc(input logic wr, input logic [15:0] ad, input logic [7:0] dt, input logic rd);
    cpu_wr = wr; a = ad; d = dt; cpu_rd = rd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    logic [15:0] ad;
    logic wr;
    ad = 16'($urandom);
    wr = 1'($urandom);
    if ($urandom_range(0, 3) == 0) begin ad = RA; wr = 1'b0; end
    else if (ad == RA) ad = 16'hFF47;
    cyc(wr, ad, 8'($urandom), 1'($urandom));
  endtask

  task automatic write(input logic [7:0] p);
    cyc(1'b1, RA, p, 1'b0);
  endtask

  task automatic clr();
    strobes = 0; dones = 0; vram_cnt = 0; ndma_lo = 0; first_wr = -1;
  endtask

  task automatic wait_idx(input int k);
    int g;
    g = 0;
    while (!(m_active && (n - m_S) / CPB == k) && g < 3000) begin idle(); g++; end
    chk("wait_idx_bound", 16'(g < 3000), 16'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dma_a"}, dma_a, 16'h0000);
    chk({tag, "_run"}, dma_run, 1'b0);
    chk({tag, "_ndma"}, oam_addr_ndma, 1'b1);
    chk({tag, "_wr"}, oam_wr, 1'b0);
    chk({tag, "_done"}, dma_done, 1'b0);
    chk({tag, "_vram"}, vram_to_oam, 1'b0);
    chk({tag, "_dout"}, reg_dout, 8'h00);
  endtask

  initial begin
    int w, g;
    reset = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0; a = 16'h0000; d = 8'h00;
    #2;
    check_reset_outputs("reset0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) idle();

    // 1: C1 copy, latency, strobe count, single done
    clr();
    write(8'hC1); w = n;
    repeat (LEN * CPB + 10) idle();
    chk("t1_first_strobe_latency", 16'(first_wr + 1 - w), 16'(2 * CPB));
    chk("t1_strobes", 16'(strobes), 16'(LEN));
    chk("t1_dones", 16'(dones), 16'd1);

    // 2: VRAM source flag window, then WRAM source
    clr();
    write(8'h85);
    repeat (LEN * CPB + 10) idle();
    chk("t2_vram_cycles", 16'(vram_cnt), 16'(LEN * CPB));
    chk("t2_ndma_low_cycles", 16'(ndma_lo), 16'(LEN * CPB));
    clr();
    write(8'hC0);
    repeat (LEN * CPB + 10) idle();
    chk("t2_vram_c0", 16'(vram_cnt), 16'd0);

    // 3: restart mid-copy
    clr();
    write(8'hC0);
    wait_idx(8'h40);
    write(8'hD0);
    repeat (LEN * CPB + 20) idle();
    chk("t3_dones", 16'(dones), 16'd1);
    chk("t3_strobes", 16'(strobes), 16'(8'h40 + 1 + LEN));

    // 4: delay expires on the final-byte edge
    clr();
    write(8'hC0);
    g = 0;
    while (!(m_active && n + 1 == m_S + LEN * CPB - CPB) && g < 3000) begin idle(); g++; end
    chk("t4_wait_bound", 16'(g < 3000), 16'd1);
    write(8'hC8);
    repeat (CPB) idle();
    chk("t4_restart_dma_a", dma_a, 16'hC800);
    chk("t4_run_kept", dma_run, 1'b1);
    chk("t4_no_done", 16'(dones), 16'd0);
    repeat (LEN * CPB + 10) idle();
    chk("t4_dones", 16'(dones), 16'd1);

    // 5: reset mid-transfer
    clr();
    write(8'hC2);
    wait_idx(8'h50);
    cpu_wr = 1'b0; cpu_rd = 1'b0; a = 16'h0000;
    #2 reset = 1'b1;
    #1 check_reset_outputs("t5_reset");
    model_reset();
    @(posedge clk); n++;
    @(negedge clk);
    reset = 1'b0;
    check_all();
    cyc(1'b0, RA, 8'h00, 1'b1);
    chk("t5_reg_oe", reg_oe, 1'b1);
    chk("t5_reg_dout", reg_dout, 8'h00);
    repeat (20) idle();
    chk("t5_no_done", 16'(dones), 16'd0);

    // 6: echo page
    clr();
    write(8'hFE);
    repeat (CPB) idle();
`ifdef OAM_DMA_ECHO_MAP_EN
    chk("t6_dma_a_first", dma_a, 16'hDE00);
`else
    chk("t6_dma_a_first", dma_a, 16'hFE00);
`endif
    chk("t6_reg_dout", reg_dout, 8'hFE);
    repeat (LEN * CPB + 10) idle();
    chk("t6_strobes", 16'(strobes), 16'(LEN));

    // random writes at random spacing
    for (int i = 0; i < 8; i++) begin
      write(8'($urandom));
      repeat ($urandom_range(0, 700)) idle();
    end
    repeat (LEN * CPB + 20) idle();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
